mem_access_unit: RTL and testbench

- Initiator side of the data-memory port, located in the MEM stage of the pipelined CPU.
- Accepts load/store requests from the pipeline and drives the word/byte memory port (mem_wr, mem_rd, mem_addr, mem_wdata, mem_byte, with combinational mem_rdata).
- Adds halfword support by splitting each halfword into two byte accesses.
- Adds sign/zero extension and misalignment/range checking, and holds the pipeline via req_ready while busy.

---
 rtl/mem_access_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage initiator for the data-memory port. Takes load/store requests from
// the pipeline and drives the word/byte memory interface. A halfword is split
// into two byte accesses: low byte at addr, high byte at addr+1. Loads are
// sign- or zero-extended. The unit stalls the pipeline via req_ready while an
// access is in flight.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready.
// req_ready is high only in IDLE. The requester holds req_op/req_addr/
// req_wdata stable while req_valid is high and req_ready is low. resp_valid
// and err_valid are single-cycle pulses with no back-pressure.
//
// Optional feature (macro MEM_ACCESS_UNIT_CHECK_EN):
//   defined   - misaligned word/halfword requests and addresses outside
//               [DM_BASE, DM_BASE+DM_BYTES) are rejected with an err_valid
//               pulse. No memory access and no response follow.
//   undefined - every request is accepted. Word addresses are forced to
//               4-byte alignment, halfword addresses to 2-byte alignment.
//               err_valid stays 0.
//
// Parameters:
//   DM_BASE   byte address of the first data-memory location
//   DM_BYTES  data-memory size in bytes (power of two)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_op                0=LW 1=LB 2=LBU 3=LH 4=LHU 5=SW 6=SB 7=SH
//   req_addr, req_wdata   byte address, store data (low byte/halfword for SB/SH)
//   resp_valid            completion pulse (loads and stores)
//   resp_rdata            extended load data, 0 for stores, held between pulses
//   err_valid             rejected-request pulse
//   mem_wr, mem_rd        memory write strobe / read enable
//   mem_addr, mem_wdata   memory byte address / write data
//   mem_byte              1 = byte access, 0 = word access
//   mem_rdata             combinational read data (zero-extended byte if mem_byte)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter int unsigned DM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err_valid,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_byte,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    // Elaboration-time parameter sanity.
    if (DM_BYTES == 0 || (DM_BYTES & (DM_BYTES - 1)) != 0) begin : g_bad_size
        $error("DM_BYTES must be a non-zero power of two");
    end
    if (DM_BASE[1:0] != 2'b00) begin : g_bad_base
        $error("DM_BASE must be word aligned");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  lo_q;     // low byte of a halfword load, captured in ACC0

    // Op classification for the latched op.
    logic q_word;
    logic q_half;
    logic q_store;

    always_comb begin
        q_word  = (op_q == OP_LW) || (op_q == OP_SW);
        q_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
        q_store = (op_q == OP_SW) || (op_q == OP_SB)  || (op_q == OP_SH);
    end

    // Request decode: address normalisation and validity.
    logic        req_word;
    logic        req_half;
    logic [31:0] req_addr_norm;
    logic        req_ok;

    always_comb begin
        req_word = (req_op == OP_LW) || (req_op == OP_SW);
        req_half = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
        // With checking on, accepted requests are already aligned and this
        // is a no-op; without it, low address bits are silently dropped.
        if (req_word) begin
            req_addr_norm = {req_addr[31:2], 2'b00};
        end else if (req_half) begin
            req_addr_norm = {req_addr[31:1], 1'b0};
        end else begin
            req_addr_norm = req_addr;
        end
    end

`ifdef MEM_ACCESS_UNIT_CHECK_EN
    logic [31:0] req_offset;
    logic        req_misaligned;
    logic        req_out_of_range;

    always_comb begin
        // Unsigned 32-bit wrap: addresses below DM_BASE become large offsets
        // and fail the range test as well.
        req_offset       = req_addr - DM_BASE;
        req_out_of_range = (req_offset >= 32'(DM_BYTES));
        req_misaligned   = (req_word && (req_addr[1:0] != 2'b00)) ||
                           (req_half && req_addr[0]);
        req_ok           = !req_misaligned && !req_out_of_range;
    end
`else
    always_comb begin
        req_ok = 1'b1;
    end
`endif

    assign req_ready = (state == IDLE);

    // Memory port is a pure decode of state and latched request, so it is
    // all-zero in IDLE and stable for the whole access cycle.
    always_comb begin
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_byte  = 1'b0;
        case (state)
            ACC0: begin
                mem_wr   = q_store;
                mem_rd   = !q_store;
                mem_addr = addr_q;
                mem_byte = !q_word;
                if (q_store) begin
                    mem_wdata = q_word ? wdata_q : {24'h0, wdata_q[7:0]};
                end
            end
            ACC1: begin
                mem_wr   = q_store;
                mem_rd   = !q_store;
                mem_addr = addr_q + 32'd1;
                mem_byte = 1'b1;
                if (q_store) begin
                    mem_wdata = {24'h0, wdata_q[15:8]};
                end
            end
            default: ;
        endcase
    end

    // Result formatting for the final access of each op.
    logic [31:0] acc0_result;
    logic [31:0] acc1_result;

    always_comb begin
        case (op_q)
            OP_LW:   acc0_result = mem_rdata;
            OP_LB:   acc0_result = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            OP_LBU:  acc0_result = {24'h0, mem_rdata[7:0]};
            default: acc0_result = 32'h0;
        endcase
        case (op_q)
            OP_LH:   acc1_result = {{16{mem_rdata[7]}}, mem_rdata[7:0], lo_q};
            OP_LHU:  acc1_result = {16'h0, mem_rdata[7:0], lo_q};
            default: acc1_result = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_LW;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            lo_q       <= 8'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            err_valid  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            err_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_ok) begin
                            op_q    <= req_op;
                            addr_q  <= req_addr_norm;
                            wdata_q <= req_wdata;
                            state   <= ACC0;
                        end else begin
                            err_valid <= 1'b1;
                        end
                    end
                end
                ACC0: begin
                    if (q_half) begin
                        lo_q  <= mem_rdata[7:0];
                        state <= ACC1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= acc0_result;
                        state      <= IDLE;
                    end
                end
                ACC1: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= acc1_result;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Bench for mem_access_unit with a little-endian byte-array data memory.
// Expected responses are pushed on accept and popped when resp_valid pulses.
// Build with +define+MEM_ACCESS_UNIT_CHECK_EN to exercise the reject path.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err_valid;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_byte;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int clash_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    mem_access_unit #(
        .DM_BASE (32'h0000_0000),
        .DM_BYTES(2048)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .err_valid (err_valid),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_byte  (mem_byte),
        .mem_rdata (mem_rdata)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;

    logic [7:0] tb_mem [0:2047];

    always_comb begin
        if (mem_byte) begin
            mem_rdata = {24'h0, tb_mem[mem_addr[10:0]]};
        end else begin
            mem_rdata = {tb_mem[{mem_addr[10:2], 2'd3}], tb_mem[{mem_addr[10:2], 2'd2}],
                         tb_mem[{mem_addr[10:2], 2'd1}], tb_mem[{mem_addr[10:2], 2'd0}]};
        end
    end

    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_byte) begin
                tb_mem[mem_addr[10:0]] <= mem_wdata[7:0];
            end else begin
                tb_mem[{mem_addr[10:2], 2'd0}] <= mem_wdata[7:0];
                tb_mem[{mem_addr[10:2], 2'd1}] <= mem_wdata[15:8];
                tb_mem[{mem_addr[10:2], 2'd2}] <= mem_wdata[23:16];
                tb_mem[{mem_addr[10:2], 2'd3}] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mem_wr) wr_cnt++;
        if (mem_wr && mem_rd) clash_cnt++;
        if (resp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: resp_valid with data %h, none required", resp_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (resp_rdata !== mon_exp) begin
                    n_bad++;
                    $display("FAIL resp_rdata: got %h, required %h", resp_rdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    // Issue one request from IDLE, expect a response after lat sampled cycles.
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp,
                           input int lat, input string name);
        int k;
        int nrdy;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready_idle: req_ready %b, required 1", name, req_ready);
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 0;
        nrdy = 0;
        do begin
            @(negedge clk);
            k++;
            if (req_ready !== 1'b1) nrdy++;
        end while (resp_valid !== 1'b1 && k < 20);
        n_cmp++;
        if (k !== lat) begin
            n_bad++;
            $display("FAIL %s_latency: %0d cycles, required %0d", name, k, lat);
        end
        n_cmp++;
        if (nrdy !== lat - 1) begin
            n_bad++;
            $display("FAIL %s_busy: req_ready low %0d cycles, required %0d", name, nrdy, lat - 1);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({resp_valid, resp_rdata, err_valid, req_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs: rv=%b rd=%h ev=%b rdy=%b, required 0 0 0 1",
                     resp_valid, resp_rdata, err_valid, req_ready);
        end
        n_cmp++;
        if ({mem_wr, mem_rd, mem_addr, mem_wdata, mem_byte} !== 67'h0) begin
            n_bad++;
            $display("FAIL reset_mem_port: wr=%b rd=%b addr=%h wdata=%h byte=%b, required all 0",
                     mem_wr, mem_rd, mem_addr, mem_wdata, mem_byte);
        end
        reset = 1'b0;
    endtask

    task automatic test_word();
        int w0;
        w0 = wr_cnt;
        run_req(OP_SW, 32'h10, 32'hDEAD_BEEF, 32'h0, 2, "sw10");
        n_cmp++;
        if (wr_cnt - w0 !== 1) begin
            n_bad++;
            $display("FAIL sw_write_count: %0d write cycles, required 1", wr_cnt - w0);
        end
        run_req(OP_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, "lw10");
    endtask

    task automatic test_byte();
        run_req(OP_LB,  32'h13, 32'h0, 32'hFFFF_FFDE, 2, "lb13");
        run_req(OP_LBU, 32'h13, 32'h0, 32'h0000_00DE, 2, "lbu13");
        run_req(OP_LB,  32'h10, 32'h0, 32'hFFFF_FFEF, 2, "lb10");
    endtask

    task automatic test_halfword();
        int w0;
        run_req(OP_SW, 32'h20, 32'h0, 32'h0, 2, "sw20");
        w0 = wr_cnt;
        run_req(OP_SH, 32'h22, 32'h0000_A55A, 32'h0, 3, "sh22");
        n_cmp++;
        if (wr_cnt - w0 !== 2) begin
            n_bad++;
            $display("FAIL sh_write_count: %0d write cycles, required 2", wr_cnt - w0);
        end
        n_cmp++;
        if ({tb_mem[11'h23], tb_mem[11'h22]} !== 16'hA55A) begin
            n_bad++;
            $display("FAIL sh_mem_bytes: [23]=%h [22]=%h, required a5 5a", tb_mem[11'h23], tb_mem[11'h22]);
        end
        run_req(OP_LH,  32'h22, 32'h0, 32'hFFFF_A55A, 3, "lh22");
        run_req(OP_LHU, 32'h22, 32'h0, 32'h0000_A55A, 3, "lhu22");
        run_req(OP_LW,  32'h20, 32'h0, 32'hA55A_0000, 2, "lw20");
    endtask

`ifdef MEM_ACCESS_UNIT_CHECK_EN
    task automatic reject_req(input logic [2:0] op, input logic [31:0] addr, input string name);
        int quiet_bad;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({err_valid, req_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL %s_err: err_valid=%b req_ready=%b, required 1 1", name, err_valid, req_ready);
        end
        quiet_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_rd || mem_wr || resp_valid) quiet_bad++;
            if (i > 0 && err_valid) quiet_bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (quiet_bad !== 0) begin
            n_bad++;
            $display("FAIL %s_quiet: %0d cycles with activity, required 0", name, quiet_bad);
        end
    endtask

    task automatic test_check();
        reject_req(OP_LW, 32'h02,  "lw02");
        reject_req(OP_SH, 32'h21,  "sh21");
        reject_req(OP_LW, 32'h800, "lw800");
    endtask
`else
    task automatic test_check();
        run_req(OP_SW, 32'h00, 32'h1234_5678, 32'h0, 2, "sw00");
        run_req(OP_LW, 32'h02, 32'h0, 32'h1234_5678, 2, "lw02_aligned");
    endtask
`endif

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h30;
        req_wdata = 32'h0000_007F;
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1;
        req_op    = OP_LB;
        req_wdata = 32'h0;
        exp_q.push_back(32'h0000_007F);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_busy: req_ready %b, required 0", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({resp_valid, req_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_overlap: resp_valid=%b req_ready=%b, required 1 1", resp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (resp_valid !== 1'b1 && k < 20);
        n_cmp++;
        if (k !== 2) begin
            n_bad++;
            $display("FAIL b2b_second_latency: %0d cycles, required 2", k);
        end
    endtask

    task automatic test_reset_abort();
        int noisy;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_LH;
        req_addr  = 32'h22;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);              // ACC0
        @(negedge clk);              // ACC1
        n_cmp++;
        if ({req_ready, mem_rd, mem_addr} !== {1'b0, 1'b1, 32'h23}) begin
            n_bad++;
            $display("FAIL abort_in_acc1: rdy=%b rd=%b addr=%h, required 0 1 00000023",
                     req_ready, mem_rd, mem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL abort_idle: req_ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid);
        end
        noisy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid || err_valid) noisy++;
        end
        n_cmp++;
        if (noisy !== 0) begin
            n_bad++;
            $display("FAIL abort_no_resp: %0d pulses, required 0", noisy);
        end
        run_req(OP_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, "lw_after_abort");
    endtask

    task automatic test_random_bytes();
        logic [31:0] a;
        logic [7:0]  d;
        for (int i = 0; i < 6; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            run_req(OP_SB,  a, {24'hABCDEF, d}, 32'h0, 2, "rnd_sb");
            run_req(OP_LBU, a, 32'h0, {24'h0, d}, 2, "rnd_lbu");
            run_req(OP_LB,  a, 32'h0, {{24{d[7]}}, d}, 2, "rnd_lb");
        end
    endtask

    task automatic test_final();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d responses missing, required 0", exp_q.size());
        end
        n_cmp++;
        if (clash_cnt !== 0) begin
            n_bad++;
            $display("FAIL rd_wr_clash: %0d cycles with both strobes, required 0", clash_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_halfword();
        test_check();
        test_back_to_back();
        test_reset_abort();
        test_random_bytes();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
